// File: rtl/fir_mac_engine.sv
// Serial 5-tap FIR multiply-accumulate stage: captures the delay-line taps on start,
// runs one MAC per cycle, then rounds, shifts and saturates to a single output sample.
module fir_mac_engine #(
  parameter int NUM_TAPS = 5,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 35,
  parameter int SHIFT    = 15
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [NUM_TAPS-1:0][DATA_W-1:0]  taps_i,
  input  logic                             coef_we_i,
  input  logic [2:0]                       coef_addr_i,
  input  logic [DATA_W-1:0]                coef_wdata_i,
  output logic                             coef_ready_o,
  output logic [DATA_W-1:0]                y_o,
  output logic                             y_valid_o,
  output logic                             busy_o,
  output logic                             overrun_o,
  input  logic                             overrun_clr_i
);

  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_K = ACC_W'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(1 << (DATA_W - 1)));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx;
  logic signed [DATA_W-1:0]  tap_q  [NUM_TAPS];
  logic signed [DATA_W-1:0]  coef_q [NUM_TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext, rnd, shr;
  logic [DATA_W-1:0]         y_sat;
  logic                      coef_wr;

  assign coef_ready_o = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign coef_wr      = coef_we_i && coef_ready_o && (int'(coef_addr_i) < NUM_TAPS);

  assign prod     = tap_q[idx] * coef_q[idx];
  assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Round half-up, arithmetic shift, then clamp to the signed output range.
  assign rnd = acc + RND_K;
  assign shr = rnd >>> SHIFT;
  assign y_sat = (shr > Y_MAX) ? Y_MAX[DATA_W-1:0] :
                 (shr < Y_MIN) ? Y_MIN[DATA_W-1:0] : shr[DATA_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = MAC;
      MAC:     if (idx == LAST_IDX) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      y_o       <= '0;
      y_valid_o <= 1'b0;
      overrun_o <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        tap_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      y_valid_o <= 1'b0;
      // A new overrun outranks a simultaneous clear.
      if (start_i && busy_o)   overrun_o <= 1'b1;
      else if (overrun_clr_i)  overrun_o <= 1'b0;
      if (coef_wr) coef_q[coef_addr_i[IDX_W-1:0]] <= coef_wdata_i;
      case (state)
        IDLE: if (start_i) begin
          for (int i = 0; i < NUM_TAPS; i++) tap_q[i] <= taps_i[i];
          acc <= '0;
          idx <= '0;
        end
        MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
        end
        OUT: begin
          y_o       <= y_sat;
          y_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: an arithmetic reference model checked every cycle,
// plus literal expectations for the hand-worked test vectors.
module tb_fir_mac_engine;
  localparam int NT = 5;
  localparam int DW = 16;

  logic clk = 0, rst = 1, start = 0, coef_we = 0, overrun_clr = 0;
  logic [NT-1:0][DW-1:0] taps = '0;
  logic [2:0]            coef_addr = '0;
  logic [DW-1:0]         coef_wdata = '0;
  logic                  coef_ready, y_valid, busy, overrun;
  logic [DW-1:0]         y;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  fir_mac_engine #(.NUM_TAPS(NT), .DATA_W(DW), .ACC_W(35), .SHIFT(15)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .taps_i(taps),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata),
    .coef_ready_o(coef_ready), .y_o(y), .y_valid_o(y_valid), .busy_o(busy),
    .overrun_o(overrun), .overrun_clr_i(overrun_clr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: signed dot product, round half-up, >>15, clamp to 16 bits.
  function automatic logic [DW-1:0] model_y(input logic [NT-1:0][DW-1:0] t, input logic [DW-1:0] c [NT]);
    longint acc, r;
    acc = 0;
    for (int i = 0; i < NT; i++) acc += longint'($signed(t[i])) * longint'($signed(c[i]));
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r[DW-1:0];
  endfunction

  // Transaction-level model: a start while idle launches a result due 6 edges later.
  logic [DW-1:0] mcoef [NT] = '{default: '0};
  int            cnt = 0;
  logic [DW-1:0] my = '0, pend = '0;
  logic          mvalid = 0, movr = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cnt = 0; my = '0; pend = '0; mvalid = 0; movr = 0;
      for (int i = 0; i < NT; i++) mcoef[i] = '0;
    end else begin
      automatic bit was_busy = (cnt != 0);
      mvalid = 0;
      if (was_busy) begin
        cnt--;
        if (cnt == 0) begin my = pend; mvalid = 1; end
      end
      if (start && was_busy) movr = 1;
      else if (overrun_clr)  movr = 0;
      if (!was_busy && coef_we && coef_addr < NT) mcoef[coef_addr] = coef_wdata;
      if (!was_busy && start) begin pend = model_y(taps, mcoef); cnt = 6; end
    end
  end

  initial forever begin
    @(negedge clk);
    check("y_valid", y_valid, mvalid);
    check("y", y, my);
    check("busy", busy, cnt != 0);
    check("coef_ready", coef_ready, cnt == 0);
    check("overrun", overrun, movr);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wcoef(input logic [2:0] a, input logic [DW-1:0] d);
    coef_we = 1; coef_addr = a; coef_wdata = d;
    cyc();
    coef_we = 0;
  endtask

  task automatic set_all(input logic [DW-1:0] c0, c1, c2, c3, c4);
    wcoef(0, c0); wcoef(1, c1); wcoef(2, c2); wcoef(3, c3); wcoef(4, c4);
  endtask

  task automatic go(input logic [NT-1:0][DW-1:0] t);
    taps = t; start = 1;
    cyc();
    start = 0;
  endtask

  task automatic wait_valid(input string nm, input logic [DW-1:0] exp, output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (!y_valid && lat < 20) begin
      if (busy) nbusy++;
      cyc();
      lat++;
    end
    check({nm, "_seen"}, y_valid, 1'b1);
    check(nm, y, exp);
  endtask

  logic [DW-1:0] cv [NT];
  int lat, nb, nv;

  initial begin
    repeat (2) cyc();
    rst = 0;
    cyc();

    // Model pins against hand-worked values
    cv = '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
    check("pin_375", model_y({16'd500, 16'd400, 16'd300, 16'd200, 16'd100}, cv), 16'd375);
    cv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    check("pin_sat_neg", model_y({5{16'h8000}}, cv), 16'h8000);

    // 1: basic Q15 quarter-gain filter
    set_all(16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000);
    go({16'd500, 16'd400, 16'd300, 16'd200, 16'd100});
    wait_valid("basic", 16'd375, lat, nb);
    check("latency", lat, 6);
    check("busy_cycles", nb, 6);

    // 2: rounding at the half-LSB boundary; out-of-range address is ignored
    set_all(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    wcoef(5, 16'h7FFF);
    go({64'h0, 16'h4000});
    wait_valid("rnd_half", 16'd1, lat, nb);
    go({64'h0, 16'h3FFF});
    wait_valid("rnd_below", 16'd0, lat, nb);
    go({64'h0, 16'hC000});
    wait_valid("rnd_neg", 16'd0, lat, nb);

    // 3: saturation both ways
    set_all(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    go({5{16'h7FFF}});
    wait_valid("sat_pos", 16'h7FFF, lat, nb);
    go({5{16'h8000}});
    wait_valid("sat_neg", 16'h8000, lat, nb);

    // 4: overrun, dropped write while busy, sticky flag and clear
    set_all(16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000);
    go({16'd500, 16'd400, 16'd300, 16'd200, 16'd100});
    cyc();
    go({5{16'h7FFF}});
    check("overrun_set", overrun, 1'b1);
    wcoef(0, 16'h7FFF);
    wait_valid("overrun_keep", 16'd375, lat, nb);
    go({64'h0, 16'd100});
    wait_valid("write_dropped", 16'd25, lat, nb);
    check("overrun_sticky", overrun, 1'b1);
    overrun_clr = 1;
    cyc();
    overrun_clr = 0;
    check("overrun_clr", overrun, 1'b0);

    // 5: reset in the middle of MAC
    go({16'd500, 16'd400, 16'd300, 16'd200, 16'd100});
    cyc(); cyc();
    #2 rst = 1;
    cyc();
    check("rst_y", y, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", coef_ready, 1'b1);
    rst = 0;
    nv = 0;
    repeat (10) begin cyc(); if (y_valid) nv++; end
    check("rst_no_valid", nv, 0);
    go({16'd500, 16'd400, 16'd300, 16'd200, 16'd100});
    wait_valid("rst_coef_zero", 16'd0, lat, nb);

    // 6: back-to-back at full rate, random taps against the model
    set_all(16'h1234, 16'hF800, 16'h4000, 16'h0100, 16'h7000);
    nv = 0;
    for (int n = 0; n < 20; n++) begin
      go({$urandom(), $urandom(), $urandom()});
      repeat (6) cyc();
      if (y_valid) nv++;
    end
    check("b2b_count", nv, 20);
    check("b2b_no_overrun", overrun, 1'b0);
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
